prog_frame_loader: RTL
======================

Name: prog_frame_loader

Overview:
- Programming front-end between the UART byte receiver (rx_dv/rx_byte stream) and the ICCM write port.
- Parses a framed boot image: magic byte, 16-bit word count, little-endian 32-bit words, then an 8-bit checksum.
- Issues one ICCM word write per received word and holds the core in reset until a good frame completes.
- Reports busy/done/error status for the boot LED and the reset manager.

Parameters:
- AddrWidth, 12, width of the ICCM word address output.
- MaxWords, 1024, largest accepted word count; larger counts are rejected.
- Magic, 8'hA5, frame start byte.
- TimeoutCycles, 1000000, inter-byte timeout in clk_i cycles. Used only with the optional feature.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- prog_i  in  1  programming request, level; a rising edge starts a load.
- rx_dv_i  in  1  one-cycle strobe: rx_byte_i is valid.
- rx_byte_i  in  8  received byte.
- we_o  out  1  ICCM write strobe, one cycle per word.
- addr_o  out  AddrWidth  ICCM word index.
- wdata_o  out  32  ICCM write data.
- reset_no  out  1  active-low core hold reset, fed to the reset manager.
- busy_o  out  1  frame in progress.
- done_o  out  1  sticky: last frame loaded and checksum matched.
- err_o  out  1  sticky: last frame failed.

Interface (already decided):
- One clock; reset is synchronous and active-high.
- Clock and reset ports are clk_i and rst_i; this polarity and synchronicity are fixed.

Behaviour:
- Reset values: we_o=0, addr_o=0, wdata_o=0, reset_no=1, busy_o=0, done_o=0, err_o=0. State is IDLE.
- prog_i is registered once; the start condition is a rising edge of prog_i.
- States: IDLE, MAGIC, LEN0, LEN1, DATA, CSUM, DONE, ERROR.
- IDLE/DONE/ERROR, on start:
  - go to MAGIC;
  - clear done_o, err_o, word counter, byte counter and running sum;
  - drive reset_no=0 and busy_o=1 from the next cycle.
- A byte arriving in the start cycle is ignored. Bytes are accepted only while in MAGIC or later states.
- MAGIC: a byte equal to Magic goes to LEN0; any other byte is discarded and the state stays MAGIC (resync).
- LEN0/LEN1: capture the count low byte, then the high byte.
  - After LEN1: count==0 goes to CSUM; count>MaxWords goes to ERROR; otherwise go to DATA.
- DATA:
  - Bytes assemble little-endian (first byte is bits 7:0).
  - Every data byte is added to an 8-bit running sum, modulo 256.
  - On the 4th byte, the cycle after its rx_dv_i: we_o=1 for one cycle, wdata_o = assembled word, addr_o = word counter zero-extended.
  - The word counter then increments. When it reaches count, go to CSUM.
  - Latency is one cycle from the 4th byte's rx_dv_i to we_o.
- CSUM: the next byte is compared with the running sum. Equal goes to DONE; not equal goes to ERROR.
- DONE: done_o=1, busy_o=0, reset_no=1 from the cycle after entry.
- ERROR: err_o=1, busy_o=0, and reset_no stays 0 (core held) until the next start or rst_i.
- prog_i falling while busy_o=1 aborts to ERROR. This takes priority over a same-cycle rx_dv_i; that byte is dropped and no write is issued.
- Word counter is 16 bits and never wraps: the count is bounded by MaxWords. addr_o uses the low AddrWidth bits.
- rst_i during a load: immediate return to reset values. No partial write is emitted afterwards.
- rx_dv_i is never back-pressured. Back-to-back strobes on consecutive cycles must be handled.

Optional Feature:
- Macro: PROG_TIMEOUT_EN.
- Defined: a counter reloads on every accepted byte and on start. In MAGIC through CSUM, TimeoutCycles cycles without rx_dv_i goes to ERROR.
- Undefined: no counter; the block waits indefinitely for bytes.

Decomposition:
- Shared package prog_loader_pkg holds:
  - the state enum prog_state_e;
  - PROG_MAGIC;
  - the default MaxWords;
  - the width constants.
- One sub-module is natural: prog_byte_packer. It holds the byte counter, the little-endian word assembly and the running sum, and reports word_valid and sum.

Test Plan:
- Start, then A5 02 00 | 13 00 00 00 | 93 00 10 00 | csum B6 -> writes addr0=32'h00000013 and addr1=32'h00100093; done_o=1, reset_no=1.
- Same frame with csum B7 -> both writes occur; err_o=1, reset_no stays 0, done_o=0.
- Garbage FF 00 before A5 01 00 | EF BE AD DE | csum 38 -> garbage ignored; single write of 32'hDEADBEEF at addr0; done_o=1.
- Length 0x0401 (1025) -> ERROR right after the LEN1 byte; no writes.
- Length 0 then csum 00 -> DONE with no writes.
- prog_i dropped mid-word, or rst_i pulsed mid-frame -> ERROR (or reset values, respectively); no we_o pulse.
  - With PROG_TIMEOUT_EN and TimeoutCycles=16: a stall of 16 cycles after LEN1 -> err_o=1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART boot-image frame loader.
// Frame layout: magic byte, 16-bit little-endian word count, data words, 8-bit checksum.
package prog_loader_pkg;

    localparam int PROG_BYTE_W    = 8;
    localparam int PROG_WORD_W    = 32;
    localparam int PROG_CNT_W     = 16;
    localparam int PROG_ADDR_W    = 12;
    localparam int PROG_MAX_WORDS = 1024;

    localparam logic [PROG_BYTE_W-1:0] PROG_MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAGIC = 3'd1,
        ST_LEN0  = 3'd2,
        ST_LEN1  = 3'd3,
        ST_DATA  = 3'd4,
        ST_CSUM  = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERROR = 3'd7
    } prog_state_e;

    // States in which a frame is being received (busy, core held).
    function automatic logic is_loading(input prog_state_e st);
        return (st == ST_MAGIC) || (st == ST_LEN0) || (st == ST_LEN1) ||
               (st == ST_DATA)  || (st == ST_CSUM);
    endfunction

endpackage

// File: rtl/prog_byte_packer.sv
// Little-endian byte-to-word assembler with an 8-bit modulo-256 running sum.
// word_valid/word are combinational on the 4th byte so the caller can register the write.
module prog_byte_packer
    import prog_loader_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear,
    input  logic                   byte_valid,
    input  logic [PROG_BYTE_W-1:0] byte_in,
    output logic                   word_valid,
    output logic [PROG_WORD_W-1:0] word,
    output logic [PROG_BYTE_W-1:0] sum
);

    logic [1:0]  cnt_r;
    logic [23:0] low_r;
    logic [7:0]  sum_r;

    assign word_valid = byte_valid && (cnt_r == 2'd3);
    assign word       = {byte_in, low_r};
    assign sum        = sum_r;

    // Byte position counter, lower-byte capture and running checksum.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            cnt_r <= 2'd0;
            low_r <= 24'd0;
            sum_r <= 8'd0;
        end else if (byte_valid) begin
            cnt_r <= cnt_r + 2'd1;
            sum_r <= sum_r + byte_in;
            case (cnt_r)
                2'd0:    low_r[7:0]   <= byte_in;
                2'd1:    low_r[15:8]  <= byte_in;
                2'd2:    low_r[23:16] <= byte_in;
                default: low_r        <= low_r;
            endcase
        end
    end

endmodule

// File: rtl/prog_frame_loader.sv
// UART boot-image loader: parses the frame, writes ICCM words, holds the core in reset
// until a good frame completes. Optional inter-byte timeout: define PROG_TIMEOUT_EN.
module prog_frame_loader
    import prog_loader_pkg::*;
#(
    parameter int                     AddrWidth     = PROG_ADDR_W,
    parameter int                     MaxWords      = PROG_MAX_WORDS,
    parameter logic [PROG_BYTE_W-1:0] Magic         = PROG_MAGIC,
    parameter int                     TimeoutCycles = 1000000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   prog_i,
    input  logic                   rx_dv_i,
    input  logic [PROG_BYTE_W-1:0] rx_byte_i,
    output logic                   we_o,
    output logic [AddrWidth-1:0]   addr_o,
    output logic [PROG_WORD_W-1:0] wdata_o,
    output logic                   reset_no,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    prog_state_e             state_r, state_next;
    logic                    prog_r;
    logic [PROG_CNT_W-1:0]   count_r, count_next;
    logic [PROG_CNT_W-1:0]   wcnt_r, wcnt_next;
    logic [PROG_BYTE_W-1:0]  len_lo_r, len_lo_next;
    logic [PROG_CNT_W-1:0]   len_s;
    logic                    we_next;
    logic                    start_s, abort_s, timeout_s, byte_s;
    logic                    clear_s, pack_valid_s, word_valid_s;
    logic [PROG_WORD_W-1:0]  word_s;
    logic [PROG_BYTE_W-1:0]  sum_s;

    assign start_s      = prog_i && !prog_r && !is_loading(state_r);
    assign abort_s      = prog_r && !prog_i && is_loading(state_r);
    assign byte_s       = rx_dv_i && !abort_s && !timeout_s;
    assign clear_s      = start_s;
    assign pack_valid_s = byte_s && (state_r == ST_DATA);
    assign len_s        = {rx_byte_i, len_lo_r};

`ifdef PROG_TIMEOUT_EN
    logic [31:0] tmo_r;

    // Idle-cycle counter, restarted by any byte and whenever no frame is in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i || !is_loading(state_r) || rx_dv_i) begin
            tmo_r <= 32'd0;
        end else begin
            tmo_r <= tmo_r + 32'd1;
        end
    end

    assign timeout_s = is_loading(state_r) && !rx_dv_i && (tmo_r == 32'(TimeoutCycles - 1));
`else
    logic unused_tmo_s;
    assign unused_tmo_s = (TimeoutCycles == 0);
    assign timeout_s    = 1'b0;
`endif

    prog_byte_packer u_packer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear      (clear_s),
        .byte_valid (pack_valid_s),
        .byte_in    (rx_byte_i),
        .word_valid (word_valid_s),
        .word       (word_s),
        .sum        (sum_s)
    );

    // Next-state and frame-field decode.
    always_comb begin
        state_next  = state_r;
        count_next  = count_r;
        wcnt_next   = wcnt_r;
        len_lo_next = len_lo_r;
        we_next     = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_s) begin
                    state_next = ST_MAGIC;
                    wcnt_next  = 16'd0;
                    count_next = 16'd0;
                end else begin
                    state_next = state_r;
                end
            end
            ST_MAGIC: begin
                if (byte_s && (rx_byte_i == Magic)) state_next = ST_LEN0;
                else                                state_next = ST_MAGIC;
            end
            ST_LEN0: begin
                if (byte_s) begin
                    len_lo_next = rx_byte_i;
                    state_next  = ST_LEN1;
                end else begin
                    state_next  = ST_LEN0;
                end
            end
            ST_LEN1: begin
                if (byte_s) begin
                    count_next = len_s;
                    if (len_s == 16'd0)              state_next = ST_CSUM;
                    else if (len_s > 16'(MaxWords))  state_next = ST_ERROR;
                    else                             state_next = ST_DATA;
                end else begin
                    state_next = ST_LEN1;
                end
            end
            ST_DATA: begin
                if (word_valid_s) begin
                    we_next   = 1'b1;
                    wcnt_next = wcnt_r + 16'd1;
                    if ((wcnt_r + 16'd1) == count_r) state_next = ST_CSUM;
                    else                             state_next = ST_DATA;
                end else begin
                    state_next = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (byte_s) state_next = (rx_byte_i == sum_s) ? ST_DONE : ST_ERROR;
                else        state_next = ST_CSUM;
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort_s || timeout_s) begin
            state_next = ST_ERROR;
        end else begin
            state_next = state_next;
        end
    end

    // State, counters and registered outputs; prog_r resets high so a level held
    // through reset does not start a load on its own.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            prog_r   <= 1'b1;
            count_r  <= 16'd0;
            wcnt_r   <= 16'd0;
            len_lo_r <= 8'd0;
            we_o     <= 1'b0;
            addr_o   <= '0;
            wdata_o  <= 32'd0;
            reset_no <= 1'b1;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state_r  <= state_next;
            prog_r   <= prog_i;
            count_r  <= count_next;
            wcnt_r   <= wcnt_next;
            len_lo_r <= len_lo_next;
            we_o     <= we_next;
            if (we_next) begin
                addr_o  <= wcnt_r[AddrWidth-1:0];
                wdata_o <= word_s;
            end
            busy_o   <= is_loading(state_next);
            reset_no <= !(is_loading(state_next) || (state_next == ST_ERROR));
            done_o   <= (state_next == ST_DONE);
            err_o    <= (state_next == ST_ERROR);
        end
    end

endmodule
